// File: rtl/ddr_pkg.sv
// ---------------------------------------------------------------------------
// ddr_pkg
// Definitions shared by the HDR-DDR transmitter and receiver:
//   - 4-bit transfer mode codes issued by the DDR CCC controller
//   - the fixed CRC token pattern
//   - the serializer FSM state encoding
// ---------------------------------------------------------------------------
package ddr_pkg;

    localparam logic [3:0] MODE_PRE    = 4'b0000;
    localparam logic [3:0] MODE_BYTE   = 4'b0011;
    localparam logic [3:0] MODE_TOKEN  = 4'b0101;
    localparam logic [3:0] MODE_PARITY = 4'b0110;
    localparam logic [3:0] MODE_CRC    = 4'b0111;

    localparam logic [3:0] CRC_TOKEN   = 4'b1100;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SHIFT,
        ST_DONE
    } ddr_state_e;

endpackage

// File: rtl/ddr_tx_parity_acc.sv
// ---------------------------------------------------------------------------
// ddr_tx_parity_acc
// Odd/even parity accumulator over the 16-bit DDR data word.
//   i_sys_clk / i_sys_rst : clock, asynchronous active-low reset
//   i_load                : capture the contribution of i_data (BYTE load)
//   i_data                : byte being loaded
//   i_commit              : byte completed, fold its contribution in
//   i_clear               : PARITY completed, start a fresh word
//   o_odd / o_even        : XOR of odd / even word bit positions so far
// A byte only contributes once it completes, so an aborted byte leaves the
// accumulator untouched. The first byte of a word is the high half D[15:8].
// ---------------------------------------------------------------------------
module ddr_tx_parity_acc #(
    parameter int DATA_W = 8
) (
    input  logic              i_sys_clk,
    input  logic              i_sys_rst,
    input  logic              i_load,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_commit,
    input  logic              i_clear,
    output logic              o_odd,
    output logic              o_even
);

    logic                low_half_q, low_half_d;
    logic                odd_q, odd_d;
    logic                even_q, even_d;
    logic                pend_odd_q, pend_odd_d;
    logic                pend_even_q, pend_even_d;
    logic [2*DATA_W-1:0] word;

    // NOTE: every variable driven here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        pend_odd_d  = pend_odd_q;
        pend_even_d = pend_even_q;
        odd_d       = odd_q;
        even_d      = even_q;
        low_half_d  = low_half_q;

        // Place the byte in its half of the word so the odd/even split follows
        // the word bit positions rather than the byte bit positions.
        word = low_half_q ? {{DATA_W{1'b0}}, i_data} : {i_data, {DATA_W{1'b0}}};

        if (i_load) begin
            pend_odd_d  = 1'b0;
            pend_even_d = 1'b0;
            for (int i = 0; i < 2*DATA_W; i++) begin
                if (i % 2 == 1) pend_odd_d  = pend_odd_d  ^ word[i];
                else            pend_even_d = pend_even_d ^ word[i];
            end
        end

        if (i_clear) begin
            odd_d      = 1'b0;
            even_d     = 1'b0;
            low_half_d = 1'b0;
        end else if (i_commit) begin
            odd_d      = odd_q ^ pend_odd_q;
            even_d     = even_q ^ pend_even_q;
            low_half_d = ~low_half_q;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_sys_clk or negedge i_sys_rst) begin
        if (!i_sys_rst) begin
            low_half_q  <= 1'b0;
            odd_q       <= 1'b0;
            even_q      <= 1'b0;
            pend_odd_q  <= 1'b0;
            pend_even_q <= 1'b0;
        end else begin
            low_half_q  <= low_half_d;
            odd_q       <= odd_d;
            even_q      <= even_d;
            pend_odd_q  <= pend_odd_d;
            pend_even_q <= pend_even_d;
        end
    end

    assign o_odd  = odd_q;
    assign o_even = even_q;

endmodule

// File: rtl/ddr_tx.sv
// ---------------------------------------------------------------------------
// ddr_tx
// HDR-DDR serial transmitter. Serializes preamble, data byte, parity pair,
// CRC token and CRC MSB first onto SDA, one bit per SCL edge (either polarity).
//   i_sys_clk / i_sys_rst       : system clock, asynchronous active-low reset
//   i_sclgen_scl_pos/neg_edge   : one-clk pulses at SCL rise / fall
//   i_ddrccc_tx_en              : transfer enable (level); low aborts
//   i_ddrccc_tx_mode            : mode code, sampled at LOAD
//   i_ddrccc_pre                : preamble bits for PRE
//   i_regf_tx_data              : byte for BYTE, sampled at LOAD
//   i_crc_value                 : CRC for CRC, sampled at LOAD
//   o_sdahnd_tx_sda             : SDA drive value (idles at 1)
//   o_ddrccc_tx_mode_done       : one-clk pulse when a mode completes
//   o_ddrccc_error              : one-clk pulse on an illegal mode
//   o_crc_en                    : high from LOAD through DONE of a BYTE
// ---------------------------------------------------------------------------
module ddr_tx
    import ddr_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int CRC_W  = 5
) (
    input  logic              i_sys_clk,
    input  logic              i_sys_rst,
    input  logic              i_sclgen_scl_pos_edge,
    input  logic              i_sclgen_scl_neg_edge,
    input  logic              i_ddrccc_tx_en,
    input  logic [3:0]        i_ddrccc_tx_mode,
    input  logic [1:0]        i_ddrccc_pre,
    input  logic [DATA_W-1:0] i_regf_tx_data,
    input  logic [CRC_W-1:0]  i_crc_value,
    output logic              o_sdahnd_tx_sda,
    output logic              o_ddrccc_tx_mode_done,
    output logic              o_ddrccc_error,
    output logic              o_crc_en
);

    localparam int CNT_W = $clog2(DATA_W);

    ddr_state_e        state_q, state_d;
    logic [3:0]        mode_q, mode_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              sda_q, sda_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              crc_en_q, crc_en_d;

    logic [DATA_W-1:0] load_word;
    logic [CNT_W-1:0]  load_last;
    logic              load_legal;
    logic              par_load, par_commit, par_clear;
    logic              par_odd, par_even;
    logic              scl_edge;

    assign scl_edge = i_sclgen_scl_pos_edge | i_sclgen_scl_neg_edge;

    // Field to send, left-aligned so the shift register MSB is always the
    // bit on SDA; load_last is the bit count minus one.
    always_comb begin
        load_word  = '0;
        load_last  = '0;
        load_legal = 1'b1;
        case (i_ddrccc_tx_mode)
            MODE_PRE: begin
                load_word[DATA_W-1 -: 2] = i_ddrccc_pre;
                load_last                = CNT_W'(1);
            end
            MODE_BYTE: begin
                load_word = i_regf_tx_data;
                load_last = CNT_W'(DATA_W-1);
            end
            MODE_TOKEN: begin
                load_word[DATA_W-1 -: 4] = CRC_TOKEN;
                load_last                = CNT_W'(3);
            end
            MODE_PARITY: begin
                load_word[DATA_W-1 -: 2] = {par_odd, ~par_even};
                load_last                = CNT_W'(1);
            end
            MODE_CRC: begin
                load_word[DATA_W-1 -: CRC_W] = i_crc_value;
                load_last                    = CNT_W'(CRC_W-1);
            end
            default: load_legal = 1'b0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        shreg_d  = shreg_q;
        cnt_d    = cnt_q;
        sda_d    = sda_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        par_load = 1'b0;

        if (!i_ddrccc_tx_en) begin
            // Abort (or plain idling): park SDA high, drop any partial field.
            state_d = ST_IDLE;
            cnt_d   = '0;
            sda_d   = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: state_d = ST_LOAD;
                ST_LOAD: begin
                    mode_d = i_ddrccc_tx_mode;
                    if (!load_legal) begin
                        err_d   = 1'b1;
                        sda_d   = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        shreg_d  = load_word;
                        cnt_d    = load_last;
                        sda_d    = load_word[DATA_W-1];
                        state_d  = ST_SHIFT;
                        par_load = (i_ddrccc_tx_mode == MODE_BYTE);
                    end
                end
                ST_SHIFT: begin
                    if (scl_edge) begin
                        if (cnt_q != '0) begin
                            shreg_d = shreg_q << 1;
                            cnt_d   = cnt_q - CNT_W'(1);
                            sda_d   = shreg_q[DATA_W-2];
                        end else begin
                            state_d = ST_DONE;
                            done_d  = 1'b1;
                        end
                    end
                end
                // Back-to-back modes go straight to the next LOAD.
                ST_DONE: state_d = ST_LOAD;
                default: state_d = ST_IDLE;
            endcase
        end

        // Entering LOAD the mode is not latched yet, so look at the live input.
        if (state_d == ST_LOAD) begin
            crc_en_d = (i_ddrccc_tx_mode == MODE_BYTE);
        end else begin
            crc_en_d = ((state_d == ST_SHIFT) || (state_d == ST_DONE)) && (mode_d == MODE_BYTE);
        end
    end

    // DONE is only reachable through a completed field, so the parity
    // bookkeeping keys off it regardless of what en does in that cycle.
    assign par_commit = (state_q == ST_DONE) && (mode_q == MODE_BYTE);
    assign par_clear  = (state_q == ST_DONE) && (mode_q == MODE_PARITY);

    always_ff @(posedge i_sys_clk or negedge i_sys_rst) begin
        if (!i_sys_rst) begin
            state_q  <= ST_IDLE;
            mode_q   <= '0;
            shreg_q  <= '0;
            cnt_q    <= '0;
            sda_q    <= 1'b1;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            crc_en_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            shreg_q  <= shreg_d;
            cnt_q    <= cnt_d;
            sda_q    <= sda_d;
            done_q   <= done_d;
            err_q    <= err_d;
            crc_en_q <= crc_en_d;
        end
    end

    ddr_tx_parity_acc #(
        .DATA_W (DATA_W)
    ) u_parity_acc (
        .i_sys_clk (i_sys_clk),
        .i_sys_rst (i_sys_rst),
        .i_load    (par_load),
        .i_data    (i_regf_tx_data),
        .i_commit  (par_commit),
        .i_clear   (par_clear),
        .o_odd     (par_odd),
        .o_even    (par_even)
    );

    assign o_sdahnd_tx_sda       = sda_q;
    assign o_ddrccc_tx_mode_done = done_q;
    assign o_ddrccc_error        = err_q;
    assign o_crc_en              = crc_en_q;

endmodule

// File: tb/tb_ddr_tx.sv
// ---------------------------------------------------------------------------
// tb_ddr_tx
// Directed bench for ddr_tx. A transfer-level model turns each mode request
// into its expected bit list (parity from the 16-bit word definition) and a
// timeline of expected outputs; one process compares every cycle.
// ---------------------------------------------------------------------------
module tb_ddr_tx;
    import ddr_pkg::*;

    logic       sys_clk = 1'b0;
    logic       sys_rst = 1'b1;
    logic       scl_pos = 1'b0;
    logic       scl_neg = 1'b0;
    logic       tx_en   = 1'b0;
    logic [3:0] tx_mode = 4'b0000;
    logic [1:0] pre     = 2'b00;
    logic [7:0] tx_data = 8'h00;
    logic [4:0] crc_val = 5'b00000;
    logic       sda, mode_done, error, crc_en;

    ddr_tx #(
        .DATA_W (8),
        .CRC_W  (5)
    ) dut (
        .i_sys_clk             (sys_clk),
        .i_sys_rst             (sys_rst),
        .i_sclgen_scl_pos_edge (scl_pos),
        .i_sclgen_scl_neg_edge (scl_neg),
        .i_ddrccc_tx_en        (tx_en),
        .i_ddrccc_tx_mode      (tx_mode),
        .i_ddrccc_pre          (pre),
        .i_regf_tx_data        (tx_data),
        .i_crc_value           (crc_val),
        .o_sdahnd_tx_sda       (sda),
        .o_ddrccc_tx_mode_done (mode_done),
        .o_ddrccc_error        (error),
        .o_crc_en              (crc_en)
    );

    always #10 sys_clk = ~sys_clk;

    int    n_cmp = 0;
    int    n_bad = 0;
    string phase = "reset";

    // Expected outputs for the current cycle; c_sda marks cycles where SDA is defined.
    bit   chk_on = 1'b0;
    bit   c_sda  = 1'b1;
    logic e_sda  = 1'b1;
    logic e_done = 1'b0;
    logic e_err  = 1'b0;
    logic e_crc  = 1'b0;

    logic [7:0] hist[$];     // completed bytes of the current parity word
    bit         exp_bits[$]; // bits of the transfer being modelled

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s (%s): got %0h, want %0h at %0t", name, phase, act, exp, $time);
        end
    endtask

    // Parity straight from the word definition: byte j of the word sits at
    // bit offset 8 when it is the high half (even j), 0 otherwise.
    function automatic logic [1:0] model_parity();
        logic odd;
        logic even;
        int   pos;
        odd  = 1'b0;
        even = 1'b0;
        for (int j = 0; j < hist.size(); j++) begin
            for (int b = 0; b < 8; b++) begin
                pos = b + ((j % 2 == 0) ? 8 : 0);
                if (pos % 2 == 1) odd  = odd  ^ hist[j][b];
                else              even = even ^ hist[j][b];
            end
        end
        return {odd, ~even};
    endfunction

    task automatic build_bits(input logic [3:0] m, input logic [7:0] d, input logic [1:0] p,
                              input logic [4:0] c, output bit legal);
        logic [3:0] tok;
        logic [1:0] par;
        tok   = CRC_TOKEN;
        par   = model_parity();
        legal = 1'b1;
        exp_bits.delete();
        case (m)
            MODE_PRE:    for (int i = 1; i >= 0; i--) exp_bits.push_back(p[i]);
            MODE_BYTE:   for (int i = 7; i >= 0; i--) exp_bits.push_back(d[i]);
            MODE_TOKEN:  for (int i = 3; i >= 0; i--) exp_bits.push_back(tok[i]);
            MODE_PARITY: for (int i = 1; i >= 0; i--) exp_bits.push_back(par[i]);
            MODE_CRC:    for (int i = 4; i >= 0; i--) exp_bits.push_back(c[i]);
            default:     legal = 1'b0;
        endcase
    endtask

    function automatic logic [15:0] packed_bits();
        logic [15:0] v;
        v = '0;
        foreach (exp_bits[i]) v = {v[14:0], exp_bits[i]};
        return v;
    endfunction

    always @(negedge sys_clk) begin
        if (chk_on) begin
            if (c_sda) check("sda", 16'(sda), 16'(e_sda));
            check("mode_done", 16'(mode_done), 16'(e_done));
            check("error", 16'(error), 16'(e_err));
            check("crc_en", 16'(crc_en), 16'(e_crc));
        end
    end

    task automatic next_cycle();
        @(posedge sys_clk);
        #1;
        scl_pos = 1'b0;
        scl_neg = 1'b0;
        e_done  = 1'b0;
        e_err   = 1'b0;
    endtask

    task automatic go_idle(input int cycles);
        tx_en = 1'b0;
        repeat (cycles) begin
            next_cycle();
            e_sda = 1'b1;
            c_sda = 1'b1;
            e_crc = 1'b0;
        end
    endtask

    // Presents a mode in the current cycle (from idle or a DONE cycle) and
    // plays the edge pulses. Returns in the DONE (or error) cycle. When
    // stop_after >= 0 the transfer is cut after that many edges, by en drop
    // (with a coincident edge pulse) or by reset.
    task automatic xfer(input logic [3:0] m, input logic [7:0] d, input logic [1:0] p,
                        input logic [4:0] c, input int stop_after, input bit by_reset);
        bit legal;
        int n;
        build_bits(m, d, p, c, legal);
        n       = exp_bits.size();
        tx_en   = 1'b1;
        tx_mode = m;
        tx_data = d;
        pre     = p;
        crc_val = c;
        next_cycle();                       // LOAD
        e_crc = (m == MODE_BYTE);
        c_sda = 1'b0;
        next_cycle();                       // first bit on SDA, or error
        if (!legal) begin
            e_err = 1'b1;
            e_sda = 1'b1;
            c_sda = 1'b1;
            e_crc = 1'b0;
            return;
        end
        e_sda = exp_bits[0];
        c_sda = 1'b1;
        for (int k = 0; k < n; k++) begin
            if (k == stop_after) begin
                if (by_reset) begin
                    e_sda = 1'b1;
                    e_crc = 1'b0;
                    tx_en = 1'b0;
                    hist.delete();
                    #2 sys_rst = 1'b0;
                    #1;
                    check("rst_mid_sda", 16'(sda), 16'h1);
                    check("rst_mid_done", 16'(mode_done), 16'h0);
                    check("rst_mid_error", 16'(error), 16'h0);
                    check("rst_mid_crc_en", 16'(crc_en), 16'h0);
                    repeat (2) next_cycle();
                    sys_rst = 1'b1;
                end else begin
                    tx_en = 1'b0;
                    if (k % 2 == 0) scl_pos = 1'b1;
                    else            scl_neg = 1'b1;
                    next_cycle();
                    e_sda = 1'b1;
                    e_crc = 1'b0;
                end
                return;
            end
            next_cycle();
            if (k % 2 == 0) scl_pos = 1'b1;
            else            scl_neg = 1'b1;
            next_cycle();
            if (k < n - 1) begin
                e_sda = exp_bits[k+1];
            end else begin
                e_done = 1'b1;
                c_sda  = 1'b0;
            end
        end
        if (m == MODE_BYTE)   hist.push_back(d);
        if (m == MODE_PARITY) hist.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test, want completion by %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit legal;
        #1 sys_rst = 1'b0;
        #4;
        check("reset_sda", 16'(sda), 16'h1);
        check("reset_done", 16'(mode_done), 16'h0);
        check("reset_error", 16'(error), 16'h0);
        check("reset_crc_en", 16'(crc_en), 16'h0);
        repeat (3) @(posedge sys_clk);
        #1 sys_rst = 1'b1;
        chk_on = 1'b1;
        go_idle(3);

        phase = "pre_10";
        xfer(MODE_PRE, 8'h00, 2'b10, 5'b0, -1, 1'b0);
        go_idle(2);

        phase = "byte_a1";
        xfer(MODE_BYTE, 8'hA1, 2'b00, 5'b0, -1, 1'b0);
        phase = "byte_d4";
        xfer(MODE_BYTE, 8'hD4, 2'b00, 5'b0, -1, 1'b0);
        check("pin_parity_a1d4", 16'(model_parity()), 16'h3);
        phase = "parity_a1d4";
        xfer(MODE_PARITY, 8'h00, 2'b00, 5'b0, -1, 1'b0);
        go_idle(2);

        phase = "byte_00_hi";
        xfer(MODE_BYTE, 8'h00, 2'b00, 5'b0, -1, 1'b0);
        phase = "byte_00_lo";
        xfer(MODE_BYTE, 8'h00, 2'b00, 5'b0, -1, 1'b0);
        check("pin_parity_0000", 16'(model_parity()), 16'h1);
        phase = "parity_0000";
        xfer(MODE_PARITY, 8'h00, 2'b00, 5'b0, -1, 1'b0);
        go_idle(2);

        build_bits(MODE_TOKEN, 8'h00, 2'b00, 5'b0, legal);
        check("pin_token_bits", packed_bits(), 16'h000C);
        build_bits(MODE_CRC, 8'h00, 2'b00, 5'b10101, legal);
        check("pin_crc_bits", packed_bits(), 16'h0015);
        phase = "token";
        xfer(MODE_TOKEN, 8'h00, 2'b00, 5'b0, -1, 1'b0);
        phase = "crc_10101";
        xfer(MODE_CRC, 8'h00, 2'b00, 5'b10101, -1, 1'b0);
        go_idle(2);

        phase = "illegal_1111";
        xfer(4'b1111, 8'h00, 2'b00, 5'b0, -1, 1'b0);
        go_idle(3);

        phase = "byte_ff_abort";
        xfer(MODE_BYTE, 8'hFF, 2'b00, 5'b0, 3, 1'b0);
        go_idle(3);
        phase = "byte_96_restart";
        xfer(MODE_BYTE, 8'h96, 2'b00, 5'b0, -1, 1'b0);
        go_idle(2);

        phase = "pre_10_reset";
        xfer(MODE_PRE, 8'h00, 2'b10, 5'b0, 1, 1'b1);
        go_idle(2);
        phase = "pre_01_after_reset";
        xfer(MODE_PRE, 8'h00, 2'b01, 5'b0, -1, 1'b0);
        go_idle(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
